// File: rtl/latch_enable_sequencer.sv
// Latch enable sequencer: generates N enable pulses, each H cycles high
// followed by L cycles low, then a one-cycle done strobe.
// All outputs are registered; phase timing uses a down-counter that
// terminates at zero.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start; captures the phase lengths and pulse count
// HIGH   | enable asserted, counting the high phase
// LOW    | enable deasserted, counting the low phase
// DONE   | one-cycle completion strobe, then back to IDLE
module latch_enable_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [CNT_W-1:0] pulse_count,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] high_norm;
  logic [CNT_W-1:0] low_norm;
  logic [CNT_W-1:0] left_dec;
  logic             phase_end;

  // A zero-length phase is stretched to one cycle so the counter never wraps.
  assign high_norm = (high_cycles == '0) ? ONE : high_cycles;
  assign low_norm  = (low_cycles  == '0) ? ONE : low_cycles;
  assign left_dec  = left_q - ONE;
  assign phase_end = (cnt_q == '0);

  // State, captured configuration, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      high_q  <= '0;
      low_q   <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; abort beats every phase transition.
  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          high_d = high_norm;
          low_d  = low_norm;
          left_d = pulse_count;
          if (pulse_count == '0) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_HIGH;
            cnt_d   = high_norm - ONE;
          end
        end
      end
      S_HIGH: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          left_d  = '0;
        end else if (phase_end) begin
          state_d = S_LOW;
          cnt_d   = low_q - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_LOW: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          left_d  = '0;
        end else if (phase_end) begin
          left_d = left_dec;
          if (left_dec != '0) begin
            state_d = S_HIGH;
            cnt_d   = high_q - ONE;
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        left_d  = '0;
      end
    endcase
  end

  // Output decode from the upcoming state so the flops present it in-cycle.
  always_comb begin
    en_d   = (state_d == S_HIGH);
    busy_d = (state_d == S_HIGH) || (state_d == S_LOW);
    done_d = (state_d == S_DONE);
  end

  assign en          = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulses_left = left_q;

endmodule
